// File: rtl/ascon_sbox_pkg.sv
// Shared definitions for the Ascon slice-serial S-box engine: substitution
// tables, FSM encoding and the counter sizing helper.
package ascon_sbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column value is {x0,x1,x2,x3,x4} with x0 as the MSB.
    localparam logic [4:0] SBOX_FWD [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam logic [4:0] SBOX_INV [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ascon_sbox5.sv
// Single-column Ascon S-box, forward via table or boolean equations,
// optional inverse via table.
module ascon_sbox5
    import ascon_sbox_pkg::*;
#(
    parameter int TYPE   = 0,
    parameter int INV_EN = 1
) (
    input  logic [4:0] x,
    input  logic       mode,
    output logic [4:0] y
);

    logic [4:0] fwd;

    if (TYPE == 1) begin : g_eq
        // w[i] is word xi of the column; bitsliced chi-style layer.
        logic [0:4] w, a, b;
        assign w   = x;
        assign a   = {w[0] ^ w[4], w[1], w[2] ^ w[1], w[3], w[4] ^ w[3]};
        assign b   = a ^ ({~a[1], ~a[2], ~a[3], ~a[4], ~a[0]} &
                          { a[2],  a[3],  a[4],  a[0],  a[1]});
        assign fwd = {b[0] ^ b[4], b[1] ^ b[0], ~b[2], b[3] ^ b[2], b[4]};
    end else begin : g_lut
        assign fwd = SBOX_FWD[x];
    end

    if (INV_EN != 0) begin : g_inv
        assign y = mode ? SBOX_INV[x] : fwd;
    end else begin : g_fwd_only
        logic unused_mode;
        assign unused_mode = mode;
        assign y           = fwd;
    end

endmodule

// File: rtl/sbox_slice_engine.sv
// Iterative Ascon substitution layer: SLICE_W columns of the 320-bit state
// are replaced per cycle, LSB slice first, with valid/ready on both sides.
module sbox_slice_engine
    import ascon_sbox_pkg::*;
#(
    parameter int SLICE_W = 16,
    parameter int TYPE    = 0,
    parameter int INV_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] s0,
    output logic [63:0] s1,
    output logic [63:0] s2,
    output logic [63:0] s3,
    output logic [63:0] s4,
    output logic        busy
);

    localparam int NSLICE = 64 / SLICE_W;
    localparam int CW     = (log2(NSLICE) < 1) ? 1 : log2(NSLICE);

    if (SLICE_W < 1 || SLICE_W > 64 || (64 % SLICE_W) != 0) begin : g_bad_slice_w
        $error("SLICE_W must be one of 1,2,4,8,16,32,64");
    end

    state_t                    state, state_nxt;
    logic [CW-1:0]             cnt;
    logic                      mode;
    logic [4:0][63:0]          work;
    logic [5:0]                base;
    logic                      last, accept;
    logic [SLICE_W-1:0][5:0]   col_idx;
    logic [SLICE_W-1:0][4:0]   col_in, col_out;

    assign base = 6'(int'(cnt) * SLICE_W);
    assign last = (cnt == CW'(NSLICE - 1));

    for (genvar j = 0; j < SLICE_W; j++) begin : g_col
        assign col_idx[j] = base + 6'(j);
        assign col_in[j]  = {work[0][col_idx[j]], work[1][col_idx[j]], work[2][col_idx[j]],
                             work[3][col_idx[j]], work[4][col_idx[j]]};
    end

    ascon_sbox5 #(.TYPE(TYPE), .INV_EN(INV_EN)) u_sbox [SLICE_W-1:0] (
        .x    (col_in),
        .mode (mode),
        .y    (col_out)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mode  <= 1'b0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= {x4, x3, x2, x1, x0};
                mode <= (INV_EN != 0) && in_mode;
                cnt  <= '0;
            end else if (state == RUN) begin
                for (int j = 0; j < SLICE_W; j++) begin
                    for (int w = 0; w < 5; w++) begin
                        work[w][col_idx[j]] <= col_out[j][4-w];
                    end
                end
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign s0 = work[0];
    assign s1 = work[1];
    assign s2 = work[2];
    assign s3 = work[3];
    assign s4 = work[4];

endmodule
